// File: rtl/wb_pwm_capture_if.sv
// Wishbone classic bus bundle for wb_pwm_capture.
// The master drives the request side and the slave returns data and acknowledge.
interface wb_pwm_capture_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_pwm_capture.sv
// Four-channel PWM pulse-width / period capture with a Wishbone register interface.
// Widths and periods are measured in microseconds from a shared prescaler tick.
module wb_pwm_capture #(
  parameter int unsigned CLKS_PER_US = 50,
  parameter int unsigned TIMEOUT_US  = 25000
) (
  input  logic            clk,
  input  logic            reset,
  wb_pwm_capture_if.slave bus,
  input  logic [3:0]      PWMin
);
  localparam int unsigned     PW        = $clog2(CLKS_PER_US);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLKS_PER_US - 1);
  localparam logic [31:0]     TIMEOUT   = 32'(TIMEOUT_US);
  localparam logic [31:0]     CNT_MAX   = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

  logic [3:0]    sync1_q, sync2_q, sync3_q;
  logic [PW-1:0] presc_q, presc_d;
  logic          us_tick;
  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    new_q, new_d;
  logic [3:0]    valid_vec, new_set;
  logic [31:0]   width_arr  [4];
  logic [31:0]   period_arr [4];
  logic [3:0]    reg_idx;
  logic          access, status_wr;
  logic [31:0]   rd_data;
  logic          unused_bits;

  assign unused_bits = ^{bus.wb_sel_i, bus.wb_adr_i[31:6], bus.wb_adr_i[1:0]};

  assign us_tick = (presc_q == PRESC_MAX);

  always_comb begin
    presc_d = us_tick ? '0 : presc_q + 1'b1;
  end

  // Bus side: one-cycle ack, ack flop forces a gap so each access acks once.
  assign reg_idx   = bus.wb_adr_i[5:2];
  assign access    = bus.wb_stb_i & bus.wb_cyc_i & ~ack_q;
  assign status_wr = access & bus.wb_we_i & (reg_idx == 4'd0);

  always_comb begin
    rd_data = '0;
    case (reg_idx)
      4'd0:    rd_data = {24'd0, new_q, valid_vec};
      4'd1:    rd_data = width_arr[0];
      4'd2:    rd_data = width_arr[1];
      4'd3:    rd_data = width_arr[2];
      4'd4:    rd_data = width_arr[3];
      4'd5:    rd_data = period_arr[0];
      4'd6:    rd_data = period_arr[1];
      4'd7:    rd_data = period_arr[2];
      4'd8:    rd_data = period_arr[3];
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    ack_d = access;
    dat_d = (access & ~bus.wb_we_i) ? rd_data : dat_q;
    // A hardware set in the same cycle as a write-1-to-clear wins.
    new_d = (new_q & ~(status_wr ? bus.wb_dat_i[7:4] : 4'd0)) | new_set;
  end

  assign bus.wb_ack_o = bus.wb_stb_i & bus.wb_cyc_i & ack_q;
  assign bus.wb_dat_o = dat_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      presc_q <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      new_q   <= '0;
    end else begin
      sync1_q <= PWMin;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      presc_q <= presc_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      new_q   <= new_d;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    state_t      state_q, state_d;
    logic [31:0] hi_cnt_q, hi_cnt_d, per_cnt_q, per_cnt_d;
    logic [31:0] width_q, width_d, period_q, period_d;
    logic        valid_q, valid_d, set_new;
    logic        rise, fall, timeout;

    assign rise    = sync2_q[gi] & ~sync3_q[gi];
    assign fall    = ~sync2_q[gi] & sync3_q[gi];
    assign timeout = (per_cnt_q >= TIMEOUT);

    always_comb begin
      state_d   = state_q;
      width_d   = width_q;
      period_d  = period_q;
      valid_d   = valid_q;
      set_new   = 1'b0;
      hi_cnt_d  = (us_tick && hi_cnt_q != CNT_MAX) ? hi_cnt_q + 32'd1 : hi_cnt_q;
      per_cnt_d = (us_tick && per_cnt_q != CNT_MAX) ? per_cnt_q + 32'd1 : per_cnt_q;
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d   = ST_HIGH;
            hi_cnt_d  = '0;
            per_cnt_d = '0;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            state_d = ST_LOW;
            width_d = hi_cnt_q;
          end else if (timeout) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
        end
        ST_LOW: begin
          // Captures use the pre-increment count; a coincident tick is dropped.
          if (rise) begin
            state_d   = ST_HIGH;
            period_d  = per_cnt_q;
            valid_d   = 1'b1;
            set_new   = 1'b1;
            hi_cnt_d  = '0;
            per_cnt_d = '0;
          end else if (timeout) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q   <= ST_IDLE;
        hi_cnt_q  <= '0;
        per_cnt_q <= '0;
        width_q   <= '0;
        period_q  <= '0;
        valid_q   <= 1'b0;
      end else begin
        state_q   <= state_d;
        hi_cnt_q  <= hi_cnt_d;
        per_cnt_q <= per_cnt_d;
        width_q   <= width_d;
        period_q  <= period_d;
        valid_q   <= valid_d;
      end
    end

    assign valid_vec[gi]  = valid_q;
    assign new_set[gi]    = set_new;
    assign width_arr[gi]  = width_q;
    assign period_arr[gi] = period_q;
  end
endmodule

// File: tb/tb_wb_pwm_capture.sv
// Directed and randomized bench for wb_pwm_capture with CLKS_PER_US=4, TIMEOUT_US=100.
// PWM waveforms come from per-channel (high, period) pairs given in microseconds.
module tb_wb_pwm_capture;
  localparam int unsigned CPU = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] PWMin;

  wb_pwm_capture_if bus ();

  wb_pwm_capture #(.CLKS_PER_US(CPU), .TIMEOUT_US(100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .PWMin (PWMin)
  );

  always #5 clk = ~clk;

  int unsigned cycle_n = 0;
  always @(posedge clk) cycle_n <= cycle_n + 1;

  int          total = 0;
  int          bad   = 0;
  int unsigned hi_us  [4];
  int unsigned per_us [4];
  int unsigned n_per;
  logic [3:0]  en;
  int unsigned ph_start;
  logic [31:0] rd_val;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=0x%08h want=0x%08h", tag, got, want);
    end
  endtask

  // A duration of N us spans N*CPU clocks; the counter sees N or N-1 ticks.
  task automatic check_near(input string tag, input logic [31:0] got, input int unsigned want);
    logic ok;
    ok = (got == 32'(want)) || (got == 32'(want - 1));
    total++;
    assert (ok === 1'b1) else begin
      bad++;
      $error("FAIL %s: got=%0d want=%0d..%0d", tag, got, want - 1, want);
    end
  endtask

  task automatic bus_read(input logic [31:0] adr, output logic [31:0] dat);
    step();
    bus.wb_adr_i = adr;
    bus.wb_we_i  = 1'b0;
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    #1;
    check("ack_early", {31'd0, bus.wb_ack_o}, 32'd0);
    step();
    check("ack_rd", {31'd0, bus.wb_ack_o}, 32'd1);
    dat = bus.wb_dat_o;
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    $display("rd adr=0x%02h dat=0x%08h t=%0d", adr[7:0], dat, cycle_n);
  endtask

  task automatic bus_write(input logic [31:0] adr, input logic [31:0] dat);
    step();
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.wb_we_i  = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    step();
    check("ack_wr", {31'd0, bus.wb_ack_o}, 32'd1);
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    $display("wr adr=0x%02h dat=0x%08h t=%0d", adr[7:0], dat, cycle_n);
  endtask

  task automatic expect_rd(input string tag, input logic [31:0] adr, input logic [31:0] want);
    logic [31:0] d;
    bus_read(adr, d);
    check(tag, d, want);
  endtask

  task automatic near_rd(input string tag, input logic [31:0] adr, input int unsigned want);
    logic [31:0] d;
    bus_read(adr, d);
    check_near(tag, d, want);
  endtask

  function automatic logic [3:0] wave(input int unsigned t);
    logic [3:0] w;
    w = 4'h0;
    for (int c = 0; c < 4; c++)
      if (en[c] && t < n_per * per_us[c] * CPU && (t % (per_us[c] * CPU)) < hi_us[c] * CPU)
        w[c] = 1'b1;
    return w;
  endfunction

  task automatic start_phase();
    ph_start = cycle_n;
    PWMin = wave(0);
  endtask

  task automatic gen_to(input int unsigned t);
    while (cycle_n - ph_start < t) begin
      step();
      PWMin = wave(cycle_n - ph_start);
    end
  endtask

  // Let every channel time out, then clear NEW so the next phase starts from STATUS=0.
  task automatic settle();
    PWMin = 4'h0;
    repeat (130 * CPU) step();
    bus_write(32'h0, 32'hF0);
    expect_rd("settle_status", 32'h0, 32'h0);
  endtask

  initial begin
    reset        = 1'b1;
    PWMin        = 4'h0;
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_sel_i = 4'hF;
    bus.wb_dat_i = '0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state and ack timing with strobe held past the ack.
    step();
    bus.wb_adr_i = 32'h0;
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    #1;
    check("rst_ack_pre", {31'd0, bus.wb_ack_o}, 32'd0);
    step();
    check("rst_ack", {31'd0, bus.wb_ack_o}, 32'd1);
    check("rst_status", bus.wb_dat_o, 32'h0);
    step();
    check("ack_clear", {31'd0, bus.wb_ack_o}, 32'd0);
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    for (int a = 1; a <= 8; a++) expect_rd("rst_reg", 32'(a * 4), 32'h0);

    // Channel 0: 10 us high, 40 us period, NEW write-1-to-clear behaviour.
    en = 4'h1; n_per = 4; hi_us[0] = 10; per_us[0] = 40;
    start_phase();
    gen_to(45 * CPU);
    expect_rd("a_status_2nd", 32'h0, 32'h11);
    bus_write(32'h0, 32'h10);
    expect_rd("a_new_clr", 32'h0, 32'h01);
    gen_to(60 * CPU);
    expect_rd("a_new_stays", 32'h0, 32'h01);
    gen_to(85 * CPU);
    expect_rd("a_new_reset", 32'h0, 32'h11);
    bus_write(32'h0, 32'h10);
    gen_to(120 * CPU + 1);
    bus_write(32'h0, 32'h10);
    expect_rd("a_set_wins", 32'h0, 32'h11);
    gen_to(170 * CPU);
    near_rd("a_width0", 32'h04, 10);
    near_rd("a_period0", 32'h14, 40);
    expect_rd("a_unmapped", 32'h24, 32'h0);
    bus_write(32'h04, 32'hDEAD);
    near_rd("a_width0_ro", 32'h04, 10);
    settle();

    // Channel 2 loses its input and times out, then recovers.
    en = 4'h4; n_per = 2; hi_us[2] = 10; per_us[2] = 40;
    start_phase();
    gen_to(130 * CPU);
    expect_rd("b_valid_90us", 32'h0, 32'h44);
    gen_to(150 * CPU);
    expect_rd("b_timeout", 32'h0, 32'h40);
    near_rd("b_width2_kept", 32'h0C, 10);
    near_rd("b_period2_kept", 32'h1C, 40);
    start_phase();
    gen_to(5 * CPU);
    expect_rd("b_first_rise", 32'h0, 32'h40);
    gen_to(45 * CPU);
    expect_rd("b_second_rise", 32'h0, 32'h44);
    gen_to(60 * CPU);
    near_rd("b_width2", 32'h0C, 10);
    near_rd("b_period2", 32'h1C, 40);
    settle();

    // All four channels with coincident edges.
    en = 4'hF; n_per = 3;
    for (int c = 0; c < 4; c++) begin
      hi_us[c]  = 5 * (c + 1);
      per_us[c] = 50;
    end
    start_phase();
    gen_to(155 * CPU);
    expect_rd("c_status", 32'h0, 32'hFF);
    for (int c = 0; c < 4; c++) begin
      near_rd("c_width", 32'(4 + 4 * c), hi_us[c]);
      near_rd("c_period", 32'(20 + 4 * c), per_us[c]);
    end
    settle();

    // Randomized independent channels.
    for (int r = 0; r < 3; r++) begin
      int unsigned mx;
      int unsigned lo;
      mx = 0;
      for (int c = 0; c < 4; c++) begin
        hi_us[c]  = $urandom_range(20, 3);
        lo        = (hi_us[c] + 5 > 25) ? hi_us[c] + 5 : 25;
        per_us[c] = $urandom_range(40, lo);
        if (per_us[c] > mx) mx = per_us[c];
      end
      en = 4'hF; n_per = 3;
      start_phase();
      gen_to(3 * mx * CPU + 8);
      expect_rd("d_status", 32'h0, 32'hFF);
      for (int c = 0; c < 4; c++) begin
        near_rd("d_width", 32'(4 + 4 * c), hi_us[c]);
        near_rd("d_period", 32'(20 + 4 * c), per_us[c]);
      end
      settle();
    end

    // Reset mid-pulse and mid-read.
    bus_read(32'h10, rd_val);
    PWMin = 4'h1;
    repeat (20) step();
    bus.wb_adr_i = 32'h04;
    bus.wb_we_i  = 1'b0;
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("e_dat_async", bus.wb_dat_o, 32'h0);
    check("e_ack_async", {31'd0, bus.wb_ack_o}, 32'd0);
    repeat (3) step();
    check("e_ack_hold", {31'd0, bus.wb_ack_o}, 32'd0);
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    step();
    reset = 1'b0;
    repeat (20) step();
    PWMin = 4'h0;
    repeat (40) step();
    expect_rd("e_status", 32'h0, 32'h0);
    for (int c = 0; c < 4; c++) expect_rd("e_period", 32'(20 + 4 * c), 32'h0);
    for (int c = 1; c < 4; c++) expect_rd("e_width", 32'(4 + 4 * c), 32'h0);
    PWMin = 4'h1;
    repeat (10) step();
    expect_rd("e_next_rise", 32'h0, 32'h11);
    PWMin = 4'h0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_pwm_capture.md
WB_PWM_CAPTURE -- requirements
Module: wb_pwm_capture

Interface
REQ-001 SHALL have parameter CLKS_PER_US, default 50, meaning clk cycles per 1 us measurement tick (≥2).
REQ-002 SHALL have parameter TIMEOUT_US, default 25000, meaning us without a rising edge before a channel is declared lost.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports wb_stb_i, wb_cyc_i, wb_we_i  input  1 each  Wishbone strobe, cycle, write-enable.
REQ-006 SHALL have port wb_adr_i  input  32  byte address; only bits [5:2] decoded.
REQ-007 SHALL have port wb_sel_i  input  4  byte select; ignored, all accesses are full 32-bit.
REQ-008 SHALL have port wb_dat_i  input  32  write data.
REQ-009 SHALL have port wb_dat_o  output  32  registered read data.
REQ-010 SHALL have port wb_ack_o  output  1  acknowledge = wb_stb_i & wb_cyc_i & internal ack flop.
REQ-011 SHALL have port PWMin  input  4  asynchronous PWM inputs, one per channel (e.g. RC receiver).

Function
REQ-012 Register map (adr[5:2]): 0x00 STATUS, [3:0] VALID (RO), [7:4] NEW (write-1-to-clear), others read 0; 0x04/0x08/0x0C/0x10 WIDTH0..3 [us] (RO); 0x14/0x18/0x1C/0x20 PERIOD0..3 [us] (RO); unmapped reads return 0, unmapped/RO writes ignored but acked.
REQ-013 Bus cycle: when stb&cyc and ack flop is 0, ack flop sets next cycle; ack flop clears the cycle after; one ack per access, latency exactly 1 cycle.
REQ-014 Read: wb_dat_o loaded with the addressed register in the same edge that sets the ack flop; wb_dat_o holds otherwise.
REQ-015 Write: STATUS write with bit[4+n]=1 clears NEW[n], performed on the edge that sets the ack flop.
REQ-016 Each PWMin bit SHALL pass a 2-flop synchronizer then an edge detector (third flop); edges seen 3 cycles after input change.
REQ-017 Shared prescaler counts 0..CLKS_PER_US-1 and emits a 1-cycle us_tick on wrap; free-running.
REQ-018 Per channel, 32-bit counters hi_cnt and per_cnt increment on us_tick, saturating at 0xFFFFFFFF.
REQ-019 Per-channel FSM states: IDLE (no rising edge since reset/timeout), HIGH, LOW.
REQ-020 IDLE: rising edge -> HIGH, clear hi_cnt and per_cnt; falling edge ignored.
REQ-021 HIGH: falling edge -> LOW, WIDTHn <= hi_cnt; rising edge impossible (ignored).
REQ-022 LOW: rising edge -> HIGH, PERIODn <= per_cnt, VALID[n] <= 1, NEW[n] <= 1, clear hi_cnt and per_cnt.
REQ-023 Edge and us_tick in same cycle: the capture uses the pre-increment count and the counter clears (tick lost, ≤1 us error).
REQ-024 Timeout: in HIGH or LOW, when per_cnt reaches TIMEOUT_US -> IDLE, VALID[n] <= 0; WIDTHn/PERIODn retain last values; NEW[n] unchanged.
REQ-025 NEW[n] set by hardware and cleared by write in same cycle: set wins.
REQ-026 Channels fully independent; simultaneous edges on all channels SHALL be captured in the same cycle.

Reset
REQ-027 On reset assertion, asynchronously: wb_dat_o=0, ack flop=0, all WIDTH/PERIOD=0, STATUS=0, FSMs=IDLE, counters, prescaler and synchronizer flops=0.
REQ-028 A bus access in progress at reset is dropped (no ack); a pulse straddling reset deassertion is not captured until its following rising edge.

Verification (CLKS_PER_US=4, TIMEOUT_US=100)
REQ-029 Reset, read STATUS -> 0x00000000, ack exactly 1 cycle after stb&cyc, deasserted next cycle.
REQ-030 Ch0 square wave high 10 us, period 40 us, three cycles -> WIDTH0=10, PERIOD0=40 (±1), STATUS=0x11 after second rising edge.
REQ-031 Write 0x10 to STATUS -> NEW0 clears, VALID0 stays; next rising edge sets NEW0 again; write on same cycle as set -> NEW0 remains 1.
REQ-032 Hold ch2 low 120 us after valid capture -> VALID2=0 at per_cnt=100, WIDTH2/PERIOD2 unchanged; resume pulses -> VALID2 returns after second rising edge.
REQ-033 Drive all four channels with different widths (5,10,15,20 us, period 50) and identical edges -> each WIDTHn correct, STATUS=0xFF.
REQ-034 Assert reset mid-pulse and mid-bus-read -> no ack, all registers 0; first post-reset pulse yields no PERIOD/VALID update.
